regfile_stream_reader: RTL and testbench



---
 rtl/regfile_stream_reader_pkg.sv | 17 +
 rtl/regfile_stream_reader_if.sv | 14 +
 rtl/regfile_stream_reader_addr_gen.sv | 67 ++++++
 rtl/regfile_stream_reader.sv | 108 ++++++++++
 tb/tb_regfile_stream_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_stream_reader_pkg.sv
// Shared types and defaults for the register-file stream reader and its register file.
// Optional feature macro: REGFILE_READER_TRANSPOSE_EN (column-major tile walk).
package regfile_stream_reader_pkg;

  localparam int unsigned DATATYPE_SIZE_DEFAULT = 8;
  localparam int unsigned ADDR_WIDTH_DEFAULT    = 6;
  // Side of the square tile held by a full register file (8 for a 64-entry file).
  localparam int unsigned TILE_DIM              = 2 ** (ADDR_WIDTH_DEFAULT / 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/regfile_stream_reader_if.sv
// Valid/ready output stream of the register-file reader, with a last-beat marker.
interface regfile_stream_reader_if #(
  parameter int unsigned DATATYPE_SIZE = 8
);

  logic [DATATYPE_SIZE-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/regfile_stream_reader_addr_gen.sv
// Address generator (module regfile_addr_gen): idx counter, wrapping base+offset, last detect.
// With REGFILE_READER_TRANSPOSE_EN the offset can be idx with its halves swapped.
module regfile_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  cmd_load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
`ifdef REGFILE_READER_TRANSPOSE_EN
  input  logic                  transpose_i,
`endif
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH-1:0] offset;

`ifdef REGFILE_READER_TRANSPOSE_EN
  localparam int unsigned HALF = ADDR_WIDTH / 2;

  if ((ADDR_WIDTH % 2) != 0) begin : g_odd_width
    $error("regfile_addr_gen: transpose needs an even ADDR_WIDTH");
  end

  logic transpose_q;

  always_ff @(posedge CLK) begin
    if (!RSTN)           transpose_q <= 1'b0;
    else if (cmd_load_i) transpose_q <= transpose_i;
  end

  // Swapping row and column halves turns a row-major index into a column-major walk.
  assign offset = transpose_q ? {idx_q[HALF-1:0], idx_q[ADDR_WIDTH-1:HALF]}
                              : idx_q[ADDR_WIDTH-1:0];
`else
  assign offset = idx_q[ADDR_WIDTH-1:0];
`endif

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (cmd_load_i) begin
      base_q <= base_addr_i;
      len_q  <= len_i;
      idx_q  <= '0;
    end else if (step_i) begin
      idx_q  <= idx_q + ONE;
    end
  end

  // Truncation to ADDR_WIDTH bits gives the wrap past the top entry.
  assign rf_addr_o = base_q + offset;
  assign last_o    = (idx_q == len_q - ONE);

endmodule

// File: rtl/regfile_stream_reader.sv
// Read-side sequencer: sweeps a block of register-file entries onto a valid/ready stream.
// Optional macro REGFILE_READER_TRANSPOSE_EN adds a transpose input for column-major reads.
module regfile_stream_reader
  import regfile_stream_reader_pkg::*;
#(
  parameter int unsigned DATATYPE_SIZE = DATATYPE_SIZE_DEFAULT,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ADDR_WIDTH:0]      len,
`ifdef REGFILE_READER_TRANSPOSE_EN
  input  logic                     transpose,
`endif
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    rf_addr,
  input  logic [DATATYPE_SIZE-1:0] rf_rd_data,
  output logic                     done,
  regfile_stream_reader_if.master  out_if
);

  state_e                   state_q, state_d;
  logic [DATATYPE_SIZE-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     cmd_load, step, addr_last;

  regfile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .cmd_load_i  (cmd_load),
    .step_i      (step),
    .base_addr_i (base_addr),
    .len_i       (len),
`ifdef REGFILE_READER_TRANSPOSE_EN
    .transpose_i (transpose),
`endif
    .rf_addr_o   (rf_addr),
    .last_o      (addr_last)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // is only seen at a rising edge; there is no storage array to clear here.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cmd_load    = 1'b0;
    step        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            cmd_load = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_FINISH;
          end
        end
      end
      ST_FETCH: begin
        // Refill when the register is empty or its beat leaves this cycle.
        if (!out_valid_q || out_if.out_ready) begin
          out_data_d  = rf_rd_data;
          out_valid_d = 1'b1;
          out_last_d  = addr_last;
          step        = 1'b1;
          if (addr_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_if.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign busy             = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_FINISH);
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Randomized self-checking bench for regfile_stream_reader against a queue-based reference.
module tb_regfile_stream_reader;
  import regfile_stream_reader_pkg::*;

  localparam int DW    = DATATYPE_SIZE_DEFAULT;
  localparam int AW    = ADDR_WIDTH_DEFAULT;
  localparam int DEPTH = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
`ifdef REGFILE_READER_TRANSPOSE_EN
  logic          transpose = 1'b0;
`endif
  logic          busy, done;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rd_data;
  logic [DW-1:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  regfile_stream_reader_if #(.DATATYPE_SIZE(DW)) s_if ();

  regfile_stream_reader #(.DATATYPE_SIZE(DW), .ADDR_WIDTH(AW)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
`ifdef REGFILE_READER_TRANSPOSE_EN
    .transpose  (transpose),
`endif
    .busy       (busy),
    .rf_addr    (rf_addr),
    .rf_rd_data (rf_rd_data),
    .done       (done),
    .out_if     (s_if)
  );

  // Register file model: combinational read.
  assign rf_rd_data = mem[rf_addr];

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_valid"}, 32'(s_if.out_valid), 0);
    check({tag, "_last"},  32'(s_if.out_last), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_data"},  32'(s_if.out_data), 0);
    check({tag, "_addr"},  32'(rf_addr), 0);
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready and stray starts.
  task automatic run_cmd(input int base, input int n, input int mode, input bit tr,
                         input int abort_after);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held_data, exp_v;
    logic          held_last;
    bit            held = 0, seen_done = 0;
    int            cyc = 0, xfers = 0, last_xfer = 0, ready_ph = 0;
    int            budget = 4 * n + 40;

    for (int i = 0; i < n; i++) begin
      int off = tr ? (i % TILE_DIM) * TILE_DIM + i / TILE_DIM : i;
      exp_q.push_back(mem[(base + off) % DEPTH]);
    end

    @(negedge CLK);
    start     = 1'b1;
    base_addr = base[AW-1:0];
    len       = n[AW:0];
`ifdef REGFILE_READER_TRANSPOSE_EN
    transpose = tr;
`endif
    @(negedge CLK);
    start = 1'b0;

    while (cyc < budget) begin
      cyc++;
      case (mode)
        0:       s_if.out_ready = 1'b1;
        1:       s_if.out_ready = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
        default: s_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      ready_ph++;
      if (mode == 2) begin
        start     = 1'($urandom_range(0, 1));
        base_addr = AW'($urandom);
        len       = (AW + 1)'($urandom_range(0, DEPTH));
      end
      #1;
      if (held) begin
        check("stall_valid", 32'(s_if.out_valid), 1);
        check("stall_data",  32'(s_if.out_data), 32'(held_data));
        check("stall_last",  32'(s_if.out_last), 32'(held_last));
      end
      held = 0;
      if (done) begin
        start = 1'b0;
        check("done_all_beats", exp_q.size(), 0);
        check("done_after_last", cyc, (n == 0) ? 1 : last_xfer + 1);
        if (mode == 0) check("done_latency", cyc, (n == 0) ? 1 : n + 2);
        check("done_valid", 32'(s_if.out_valid), 0);
        check("done_busy",  32'(busy), 0);
        seen_done = 1;
        break;
      end
      check("busy", 32'(busy), 32'(n > 0));
      if (s_if.out_valid && s_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_overrun", xfers, n - 1);
        end else begin
          exp_v = exp_q.pop_front();
          check("beat_data", 32'(s_if.out_data), 32'(exp_v));
          check("beat_last", 32'(s_if.out_last), 32'(exp_q.size() == 0));
        end
        xfers++;
        last_xfer = cyc;
        if (abort_after >= 0 && xfers == abort_after) begin
          @(negedge CLK);
          RSTN  = 1'b0;
          start = 1'b0;
          @(negedge CLK);
          #1;
          check_idle_reset("abort");
          RSTN = 1'b1;
          repeat (8) begin
            @(negedge CLK);
            #1;
            check("abort_no_done",  32'(done), 0);
            check("abort_no_valid", 32'(s_if.out_valid), 0);
          end
          return;
        end
      end else if (s_if.out_valid) begin
        held      = 1;
        held_data = s_if.out_data;
        held_last = s_if.out_last;
      end
      @(negedge CLK);
    end

    start = 1'b0;
    check("timeout", 32'(seen_done), 1);
    if (seen_done) begin
      @(negedge CLK);
      #1;
      check("done_pulse", 32'(done), 0);
      check("idle_busy",  32'(busy), 0);
    end
  endtask

  initial begin
    bit tr_rand;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    s_if.out_ready = 1'b1;

    repeat (3) @(negedge CLK);
    #1;
    check_idle_reset("reset");
    RSTN = 1'b1;

    run_cmd(0, 64, 0, 0, -1);
    run_cmd(62, 4, 0, 0, -1);
    run_cmd(0, 8, 1, 0, -1);
    run_cmd(9, 0, 0, 0, -1);
    run_cmd(20, 16, 0, 0, 3);
    run_cmd(40, 16, 0, 0, -1);
    run_cmd(0, 64, 2, 0, -1);
`ifdef REGFILE_READER_TRANSPOSE_EN
    run_cmd(0, 64, 0, 1, -1);
    run_cmd(8, 64, 2, 1, -1);
`endif

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int r = 0; r < 10; r++) begin
      tr_rand = 0;
`ifdef REGFILE_READER_TRANSPOSE_EN
      tr_rand = 1'($urandom_range(0, 1));
`endif
      run_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
              $urandom_range(0, 2), tr_rand, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
